// File: rtl/rgb_frame_capture_if.sv
// rtl/rgb_frame_capture_if.sv - camera byte stream and pixel output bundle for rgb_frame_capture
interface rgb_frame_capture_if;
    logic        start;
    logic        abort;
    logic        camera_en;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        pix_valid;
    logic [23:0] pix_rgb;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [7:0]  pix_gray;
    logic        frame_done;
    logic        busy;

    modport master (
        output start, abort, data_valid, data_in,
        input  camera_en, pix_valid, pix_rgb, pix_x, pix_y, pix_gray, frame_done, busy
    );

    modport slave (
        input  start, abort, data_valid, data_in,
        output camera_en, pix_valid, pix_rgb, pix_x, pix_y, pix_gray, frame_done, busy
    );
endinterface

// File: rtl/rgb_frame_capture.sv
// rtl/rgb_frame_capture.sv - captures one R,G,B interleaved frame into tagged 24-bit pixels
// Optional luma output enabled by defining RGB_CAPTURE_GRAY_EN.
module rgb_frame_capture #(
    parameter int N = 450,
    parameter int M = 450
) (
    input  logic              clk,
    input  logic              rst,
    rgb_frame_capture_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    localparam logic [15:0] X_LAST = 16'(N - 1);
    localparam logic [15:0] Y_LAST = 16'(M - 1);

    logic [1:0]  state;
    logic [1:0]  phase;
    logic [7:0]  r_q;
    logic [7:0]  g_q;
    logic [15:0] x;
    logic [15:0] y;
    logic        pix_valid_q;
    logic [23:0] pix_rgb_q;
    logic [15:0] pix_x_q;
    logic [15:0] pix_y_q;
    logic [7:0]  pix_gray_q;
    logic        frame_done_q;
    logic [7:0]  gray_next;

`ifdef RGB_CAPTURE_GRAY_EN
    // Coefficients sum to 256, so the worst case (all 0xFF) is 0xFF00 and fits 16 bits.
    logic [15:0] luma;
    assign luma = 16'd77  * {8'd0, r_q}
                + 16'd150 * {8'd0, g_q}
                + 16'd29  * {8'd0, bus.data_in};
    assign gray_next = luma[15:8];
`else
    assign gray_next = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= 2'd0;
            r_q          <= 8'd0;
            g_q          <= 8'd0;
            x            <= 16'd0;
            y            <= 16'd0;
            pix_valid_q  <= 1'b0;
            pix_rgb_q    <= 24'd0;
            pix_x_q      <= 16'd0;
            pix_y_q      <= 16'd0;
            pix_gray_q   <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= CAPTURE;
                        phase <= 2'd0;
                        x     <= 16'd0;
                        y     <= 16'd0;
                    end
                end
                CAPTURE: begin
                    // Abort takes precedence over a byte arriving in the same cycle.
                    if (bus.abort) begin
                        state <= DRAIN;
                        phase <= 2'd0;
                    end else if (bus.data_valid) begin
                        case (phase)
                            2'd0: begin
                                r_q   <= bus.data_in;
                                phase <= 2'd1;
                            end
                            2'd1: begin
                                g_q   <= bus.data_in;
                                phase <= 2'd2;
                            end
                            default: begin
                                phase       <= 2'd0;
                                pix_valid_q <= 1'b1;
                                pix_rgb_q   <= {r_q, g_q, bus.data_in};
                                pix_x_q     <= x;
                                pix_y_q     <= y;
                                pix_gray_q  <= gray_next;
                                if (x == X_LAST && y == Y_LAST) begin
                                    frame_done_q <= 1'b1;
                                    state        <= DRAIN;
                                end
                                if (x == X_LAST) begin
                                    x <= 16'd0;
                                    y <= y + 16'd1;
                                end else begin
                                    x <= x + 16'd1;
                                end
                            end
                        endcase
                    end
                end
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.camera_en  = (state == CAPTURE);
    assign bus.busy       = (state != IDLE);
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_rgb    = pix_rgb_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.pix_gray   = pix_gray_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_rgb_frame_capture.sv
// tb/tb_rgb_frame_capture.sv - directed self-checking bench for rgb_frame_capture (N=4, M=2)
module tb_rgb_frame_capture;
    localparam int N = 4;
    localparam int M = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb_frame_capture_if bus();
    rgb_frame_capture #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] src [24];
    int  ptr  = 0;
    bit  gaps = 0;

    bit          m_en = 0, m_busy = 0;
    int          m_cnt = 0;
    logic        m_pv = 0, m_fd = 0;
    logic [23:0] m_rgb = 0;
    logic [15:0] m_x = 0, m_y = 0;
    logic [7:0]  m_gray = 0;
    int          pv_count = 0, fd_count = 0;
    logic [23:0] got_rgb [8];
    logic [15:0] got_x [8], got_y [8];
    logic [7:0]  got_gray [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gray_of(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
`ifdef RGB_CAPTURE_GRAY_EN
        int s;
        s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
        return 8'(s >> 8);
`else
        return (r & g & b) & 8'h00;
`endif
    endfunction

    // One clock: advance the reference model, check every output, then let the source react.
    task automatic tick();
        bit   en_src, n_en, n_busy;
        logic n_pv, n_fd;
        int   k;
        en_src = (bus.camera_en === 1'b1);
        n_en = m_en; n_pv = 1'b0; n_fd = 1'b0; n_busy = 1'b0; k = -1;
        if (rst) begin
            n_en = 0; m_cnt = 0; m_rgb = '0; m_x = '0; m_y = '0; m_gray = '0;
        end else begin
            if (!m_busy) begin
                if (bus.start) begin n_en = 1; m_cnt = 0; ptr = 0; end
            end else if (m_en) begin
                if (bus.abort) n_en = 0;
                else if (bus.data_valid) begin
                    m_cnt++;
                    if (m_cnt % 3 == 0) begin
                        k      = m_cnt / 3 - 1;
                        n_pv   = 1'b1;
                        m_rgb  = {src[3*k], src[3*k+1], src[3*k+2]};
                        m_x    = 16'(k % N);
                        m_y    = 16'(k / N);
                        m_gray = gray_of(src[3*k], src[3*k+1], src[3*k+2]);
                        n_fd   = (k == N*M - 1);
                        if (n_fd) n_en = 0;
                    end
                end
            end
            n_busy = n_en || (m_en && !n_en);
        end
        @(posedge clk);
        #1;
        m_en = n_en; m_busy = n_busy; m_pv = n_pv; m_fd = n_fd;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("camera_en",  32'(bus.camera_en),  32'(m_en));
        chk("busy",       32'(bus.busy),       32'(m_busy));
        chk("pix_valid",  32'(bus.pix_valid),  32'(m_pv));
        chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
        chk("pix_rgb",    32'(bus.pix_rgb),    32'(m_rgb));
        chk("pix_x",      32'(bus.pix_x),      32'(m_x));
        chk("pix_y",      32'(bus.pix_y),      32'(m_y));
        chk("pix_gray",   32'(bus.pix_gray),   32'(m_gray));
        if (bus.pix_valid === 1'b1)  pv_count++;
        if (bus.frame_done === 1'b1) fd_count++;
        if (k >= 0) begin
            got_rgb[k] = bus.pix_rgb; got_x[k] = bus.pix_x;
            got_y[k] = bus.pix_y;     got_gray[k] = bus.pix_gray;
        end
        bus.data_valid = en_src && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
        if (bus.data_valid) begin
            bus.data_in = (ptr < 24) ? src[ptr] : 8'hAA;
            ptr++;
        end else begin
            bus.data_in = 8'h5A;
        end
    endtask

    task automatic clear_got();
        pv_count = 0; fd_count = 0;
        for (int i = 0; i < 8; i++) begin
            got_rgb[i] = 'x; got_x[i] = 'x; got_y[i] = 'x; got_gray[i] = 'x;
        end
    endtask

    task automatic run_frame();
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 400 && m_busy; i++) tick();
        chk("frame_timeout", 32'(m_busy), 32'd0);
    endtask

    task automatic check_ramp_frame(input string tag);
        chk({tag, "_pv_count"}, 32'(pv_count), 32'd8);
        chk({tag, "_fd_count"}, 32'(fd_count), 32'd1);
        chk({tag, "_p0_rgb"}, 32'(got_rgb[0]), 32'h000102);
        chk({tag, "_p0_xy"},  {got_x[0], got_y[0]}, {16'd0, 16'd0});
        chk({tag, "_p4_rgb"}, 32'(got_rgb[4]), 32'h0C0D0E);
        chk({tag, "_p4_xy"},  {got_x[4], got_y[4]}, {16'd0, 16'd1});
        chk({tag, "_p7_rgb"}, 32'(got_rgb[7]), 32'h151617);
        chk({tag, "_p7_xy"},  {got_x[7], got_y[7]}, {16'd3, 16'd1});
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.data_valid = 1'b0; bus.data_in = 8'h00;
        for (int i = 0; i < 24; i++) src[i] = 8'(i);

        // Reset values
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_rgb",  32'(bus.pix_rgb), 32'd0);
        tick();

        // Gap-free frame; the DRAIN-cycle stray 0xAA must not produce a pixel
        clear_got();
        run_frame();
        check_ramp_frame("nogap");

        // Back-to-back start in the first IDLE cycle, with random source gaps
        gaps = 1;
        clear_got();
        run_frame();
        check_ramp_frame("gaps");
        gaps = 0;
        tick(); tick();

        // Abort after 5 bytes, then a full frame from (0,0)
        clear_got();
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 50 && m_cnt < 5; i++) tick();
        chk("abort_cnt_reached", 32'(m_cnt), 32'd5);
        bus.abort = 1'b1;
        tick();
        chk("abort_camera_en", 32'(bus.camera_en), 32'd0);
        chk("abort_pv_count", 32'(pv_count), 32'd1);
        chk("abort_fd_count", 32'(fd_count), 32'd0);
        tick(); tick();
        clear_got();
        run_frame();
        check_ramp_frame("after_abort");

        // start pulses during CAPTURE are ignored
        clear_got();
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 50 && m_cnt < 7; i++) tick();
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 400 && m_busy; i++) tick();
        chk("restart_timeout", 32'(m_busy), 32'd0);
        check_ramp_frame("start_ignored");

        // Reset in the middle of a frame
        clear_got();
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 50 && m_cnt < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_camera_en", 32'(bus.camera_en), 32'd0);
        chk("midrst_busy",      32'(bus.busy), 32'd0);
        chk("midrst_xy",        {bus.pix_x, bus.pix_y}, 32'd0);
        tick(); tick();
        chk("midrst_fd_count", 32'(fd_count), 32'd0);

        // Luma: white and a mid-tone pixel
        for (int i = 0; i < 24; i++) src[i] = 8'h00;
        src[0] = 8'hFF; src[1] = 8'hFF; src[2] = 8'hFF;
        src[3] = 8'h10; src[4] = 8'h20; src[5] = 8'h30;
        clear_got();
        run_frame();
        chk("gray_rgb1", 32'(got_rgb[1]), 32'h102030);
`ifdef RGB_CAPTURE_GRAY_EN
        chk("gray_white", 32'(got_gray[0]), 32'h0000_00FF);
        chk("gray_mid",   32'(got_gray[1]), 32'h0000_001D);
`else
        chk("gray_white", 32'(got_gray[0]), 32'd0);
        chk("gray_mid",   32'(got_gray[1]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
